layer_draw_sequencer: RTL and testbench

//  Parametrised per-pixel layer sequencer between the sprite/position logic and the line buffer writer.
//  For each pixel of the next scanline it walks the active layers, back to front.
//  For each active layer it emits one write beat carrying the winning source's ROM address.

---
 rtl/layer_draw_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_layer_draw_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_draw_sequencer.sv
// Per-pixel layer sequencer. At each line start it walks the pixels of the
// next scanline. For every pixel it snapshots the layer requests, then emits
// one write beat per active layer, back-most (layer 0) first. Each beat
// carries the ROM address of the lowest-index requesting source in that layer.
//
// Handshake: a beat is present while write_valid=1. It is transferred on the
// rising edge where write_valid && write_ready are both high. While
// write_ready is low, every beat output holds its value.
module layer_draw_sequencer #(
  parameter int NUM_LAYERS    = 4,
  parameter int SRC_PER_LAYER = 5,
  parameter int ADDR_W        = 18,
  parameter int X_W           = 10,
  parameter int H_ACTIVE      = 640,
  parameter int V_TOTAL       = 525,
  parameter int DEFAULT_ADDR  = 20,
  localparam int LID_W        = $clog2(NUM_LAYERS + 1),
  localparam int NSRC         = NUM_LAYERS * SRC_PER_LAYER
) (
  input  logic                   Clk50,
  input  logic                   Reset,
  input  logic [NSRC-1:0]        draw_req,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  input  logic [X_W-1:0]         DrawX,
  input  logic [X_W-1:0]         DrawY,
  input  logic                   write_ready,
  input  logic                   clear_overrun,
  output logic [ADDR_W-1:0]      draw_address,
  output logic [X_W-1:0]         write_X,
  output logic [X_W-1:0]         write_Y,
  output logic [LID_W-1:0]       write_which_layer,
  output logic                   write_valid,
  output logic                   line_done,
  output logic                   overrun,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_REST    = 2'd0,
    S_CAPTURE = 2'd1,
    S_LAYER   = 2'd2,
    S_ADVANCE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LID_W-1:0]      r_layer;
  logic [NUM_LAYERS-1:0] r_pend;
  logic [ADDR_W-1:0]     r_sel_addr [NUM_LAYERS];
  logic [X_W-1:0]        r_write_X;
  logic [X_W-1:0]        r_write_Y;
  logic [X_W-1:0]        r_prev_x;
  logic                  r_overrun;

  logic                  w_line_start;
  logic [X_W-1:0]        w_next_y;
  logic                  w_last_x;
  logic [NUM_LAYERS-1:0] w_cap_pend;
  logic [ADDR_W-1:0]     w_cap_addr [NUM_LAYERS];
  logic                  w_cap_any;
  logic [LID_W-1:0]      w_cap_first;
  logic                  w_nxt_any;
  logic [LID_W-1:0]      w_nxt_layer;
  logic [ADDR_W-1:0]     w_cur_addr;
  logic                  w_accept;

  // One pulse per line: DrawX wraps back to zero.
  assign w_line_start = (DrawX == '0) && (r_prev_x != '0);
  assign w_next_y     = (DrawY == X_W'(V_TOTAL - 1)) ? '0 : DrawY + X_W'(1);
  assign w_last_x     = (r_write_X == X_W'(H_ACTIVE - 1));
  assign w_accept     = (r_state == S_LAYER) && write_ready;

  // Per-layer request OR and priority address select (lowest source index wins).
  always_comb begin
    for (int l = 0; l < NUM_LAYERS; l++) begin
      w_cap_pend[l] = |draw_req[l*SRC_PER_LAYER +: SRC_PER_LAYER];
      w_cap_addr[l] = '0;
      for (int s = SRC_PER_LAYER - 1; s >= 0; s--) begin
        if (draw_req[l*SRC_PER_LAYER + s]) begin
          w_cap_addr[l] = src_addr[(l*SRC_PER_LAYER + s)*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Lowest requesting layer at capture, next pending layer above the current one, current address.
  always_comb begin
    w_cap_any   = 1'b0;
    w_cap_first = '0;
    w_nxt_any   = 1'b0;
    w_nxt_layer = '0;
    w_cur_addr  = '0;
    for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
      if (w_cap_pend[l]) begin
        w_cap_any   = 1'b1;
        w_cap_first = LID_W'(l);
      end
      if (r_pend[l] && (LID_W'(l) > r_layer)) begin
        w_nxt_any   = 1'b1;
        w_nxt_layer = LID_W'(l);
      end
      if (LID_W'(l) == r_layer) begin
        w_cur_addr = r_sel_addr[l];
      end
    end
  end

  // Next-state and beat outputs; a line start from any state restarts at CAPTURE.
  always_comb begin
    w_state_nxt       = r_state;
    write_valid       = 1'b0;
    write_which_layer = '0;
    draw_address      = ADDR_W'(DEFAULT_ADDR);
    line_done         = 1'b0;
    case (r_state)
      S_REST: begin
        w_state_nxt = S_REST;
      end
      S_CAPTURE: begin
        w_state_nxt = w_cap_any ? S_LAYER : S_ADVANCE;
      end
      S_LAYER: begin
        write_valid       = 1'b1;
        write_which_layer = r_layer + LID_W'(1);
        draw_address      = w_cur_addr;
        if (write_ready) begin
          w_state_nxt = w_nxt_any ? S_LAYER : S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        line_done   = w_last_x;
        w_state_nxt = w_last_x ? S_REST : S_CAPTURE;
      end
      default: w_state_nxt = S_REST;
    endcase
    if (w_line_start) begin
      w_state_nxt = S_CAPTURE;
    end
  end

  // State register.
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) r_state <= S_REST;
    else       r_state <= w_state_nxt;
  end

  // Pixel position, pending-layer snapshot, current layer and line-start edge detect.
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      r_write_X <= '0;
      r_write_Y <= '0;
      r_prev_x  <= '0;
      r_layer   <= '0;
      r_pend    <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) r_sel_addr[l] <= '0;
    end else begin
      r_prev_x <= DrawX;
      if (w_line_start) begin
        r_write_X <= '0;
        r_write_Y <= w_next_y;
        r_pend    <= '0;
      end else begin
        case (r_state)
          S_CAPTURE: begin
            r_pend  <= w_cap_pend;
            r_layer <= w_cap_first;
            for (int l = 0; l < NUM_LAYERS; l++) r_sel_addr[l] <= w_cap_addr[l];
          end
          S_LAYER: begin
            if (w_accept) begin
              for (int l = 0; l < NUM_LAYERS; l++) begin
                if (LID_W'(l) == r_layer) r_pend[l] <= 1'b0;
              end
              if (w_nxt_any) r_layer <= w_nxt_layer;
            end
          end
          S_ADVANCE: begin
            r_write_X <= w_last_x ? '0 : r_write_X + X_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky overrun: a line start outside REST sets it; set beats clear.
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset)                                  r_overrun <= 1'b0;
    else if (w_line_start && r_state != S_REST) r_overrun <= 1'b1;
    else if (clear_overrun)                     r_overrun <= 1'b0;
  end

  assign write_X   = r_write_X;
  assign write_Y   = r_write_Y;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_layer_draw_sequencer.sv
// Bench for layer_draw_sequencer: directed line scenarios, expected beats
// queued by the stimulus thread and popped by an independent monitor.
module tb_layer_draw_sequencer;
  localparam int NL  = 4;
  localparam int SP  = 5;
  localparam int AW  = 18;
  localparam int XW  = 10;
  localparam int LW  = 3;
  localparam int NS  = NL * SP;
  localparam int EW  = LW + 2*XW + AW;

  logic          Clk50 = 1'b0;
  logic          Reset;
  logic [NS-1:0] draw_req;
  logic [NS*AW-1:0] src_addr;
  logic [XW-1:0] DrawX, DrawY;
  logic          write_ready, clear_overrun;
  logic [AW-1:0] draw_address;
  logic [XW-1:0] write_X, write_Y;
  logic [LW-1:0] write_which_layer;
  logic          write_valid, line_done, overrun;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_ld  = 0;
  logic [EW-1:0] exp_q[$];

  layer_draw_sequencer dut (
    .Clk50(Clk50), .Reset(Reset), .draw_req(draw_req), .src_addr(src_addr),
    .DrawX(DrawX), .DrawY(DrawY), .write_ready(write_ready),
    .clear_overrun(clear_overrun), .draw_address(draw_address),
    .write_X(write_X), .write_Y(write_Y), .write_which_layer(write_which_layer),
    .write_valid(write_valid), .line_done(line_done), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 Clk50 = ~Clk50;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] beat(input logic [LW-1:0] lid, input logic [XW-1:0] y,
                                         input logic [XW-1:0] x, input logic [AW-1:0] a);
    return {lid, y, x, a};
  endfunction

  // Monitor: sample mid-low-phase, after the driver's negedge updates.
  always @(negedge Clk50) begin
    #2;
    if (Reset === 1'b0 && write_valid && write_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h required none",
                 beat(write_which_layer, write_Y, write_X, draw_address));
      end else begin
        check("beat", 64'(beat(write_which_layer, write_Y, write_X, draw_address)),
              64'(exp_q.pop_front()));
      end
    end
    if (Reset === 1'b0 && line_done) n_ld++;
  end

  // Driver tasks
  task automatic pulse_line();
    @(negedge Clk50); DrawX = 10'd1;
    @(negedge Clk50); DrawX = 10'd0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk50); #1;
      if (write_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_line_done(input int start, output int cycles);
    cycles = start;
    while (cycles < 4000) begin
      @(negedge Clk50); #1;
      cycles++;
      if (line_done) return;
    end
    cycles = -1;
  endtask

  initial begin
    bit ok;
    int c;
    Reset = 1'b1; draw_req = '0; DrawX = '0; DrawY = '0;
    write_ready = 1'b0; clear_overrun = 1'b0;
    for (int i = 0; i < NS; i++) src_addr[i*AW +: AW] = AW'(18'h100 + i);
    repeat (3) @(negedge Clk50);
    #1;
    check("rst_valid", write_valid, 0);
    check("rst_addr", draw_address, 20);
    check("rst_lid", write_which_layer, 0);
    check("rst_state", dbg_state, 0);
    @(negedge Clk50); Reset = 1'b0;

    // Reset in the middle of a beat
    draw_req = '0; draw_req[0] = 1'b1; DrawY = 10'd5;
    pulse_line();
    wait_valid(10, ok);
    check("t1_valid_seen", ok, 1);
    check("t1_lid", write_which_layer, 1);
    check("t1_addr", draw_address, 18'h100);
    check("t1_y", write_Y, 6);
    Reset = 1'b1; #1;
    check("t1_rst_valid", write_valid, 0);
    check("t1_rst_lid", write_which_layer, 0);
    check("t1_rst_addr", draw_address, 20);
    check("t1_rst_xy", {write_X, write_Y}, 0);
    check("t1_rst_flags", {overrun, line_done}, 0);
    check("t1_rst_state", dbg_state, 0);
    @(negedge Clk50); Reset = 1'b0; write_ready = 1'b1;
    repeat (6) @(negedge Clk50);
    #1;
    check("t1_stay_rest", dbg_state, 0);
    check("t1_stay_idle", write_valid, 0);

    // Full line: layer0 src1 and layer3 src4
    draw_req = '0; draw_req[1] = 1'b1; draw_req[19] = 1'b1; DrawY = 10'd9;
    for (int x = 0; x < 640; x++) begin
      exp_q.push_back(beat(3'd1, 10'd10, XW'(x), 18'h101));
      exp_q.push_back(beat(3'd4, 10'd10, XW'(x), 18'h113));
    end
    pulse_line();
    wait_line_done(0, c);
    check("t2_line_cycles", c, 2560);
    check("t2_overrun", overrun, 0);
    @(negedge Clk50); #1;
    check("t2_rest", dbg_state, 0);
    check("t2_x_wrap", write_X, 0);
    check("t2_q_empty", exp_q.size(), 0);

    // Priority in layer 2, layer-1 beat held for 7 cycles, then overrun restart
    write_ready = 1'b0;
    draw_req = '0; draw_req[7] = 1'b1; draw_req[10] = 1'b1; draw_req[13] = 1'b1;
    DrawY = 10'd100;
    for (int x = 0; x < 300; x++) begin
      exp_q.push_back(beat(3'd2, 10'd101, XW'(x), 18'h107));
      exp_q.push_back(beat(3'd3, 10'd101, XW'(x), 18'h10A));
    end
    exp_q.push_back(beat(3'd2, 10'd101, 10'd300, 18'h107));
    pulse_line();
    wait_valid(10, ok);
    check("t4_valid_seen", ok, 1);
    for (int i = 0; i < 7; i++) begin
      check("t4_hold", {write_valid, write_which_layer, write_X, draw_address},
            {1'b1, 3'd2, 10'd0, 18'h107});
      @(negedge Clk50);
      if (i == 6) write_ready = 1'b1;
      #1;
    end
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (write_X == 10'd300 && write_valid && write_which_layer == 3'd2) ok = 1'b1;
      else begin
        @(negedge Clk50); #1;
      end
    end
    check("t6_reach_x300", ok, 1);
    DrawX = 10'd1;
    @(negedge Clk50);
    DrawX = 10'd0; write_ready = 1'b0; draw_req = '0; DrawY = 10'd524;
    @(negedge Clk50); #1;
    check("t6_overrun_set", overrun, 1);
    check("t6_restart_x", write_X, 0);
    check("t6_wrap_y", write_Y, 0);
    check("t6_capture", dbg_state, 1);
    check("t6_no_beat", write_valid, 0);

    // Empty line after the restart
    wait_line_done(1, c);
    check("t5_line_cycles", c, 1280);
    check("t6_sticky", overrun, 1);
    @(negedge Clk50); #1;
    check("t5_rest", dbg_state, 0);
    check("t5_x_wrap", write_X, 0);
    clear_overrun = 1'b1;
    @(negedge Clk50); clear_overrun = 1'b0; #1;
    check("t6_overrun_clr", overrun, 0);

    repeat (4) @(negedge Clk50);
    #3;
    check("q_empty", exp_q.size(), 0);
    check("line_done_count", n_ld, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
